// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program counter and instruction-fetch sequencer for the picoMIPS core.
//   Steps through the program memory one word per enabled cycle and applies
//   the decoder's control requests: absolute/relative branch, wait for an
//   operator handshake (press then release), and halt.
//
// Optional build macro:
//   PC_HS_SYNC_EN  - when defined, hs_in goes through a 2-flop synchronizer
//                    (reset to 0) before the FSM sees it. This adds two cycles
//                    of latency to both press and release detection. Leave it
//                    undefined only when hs_in is already synchronous to clk.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   en        in   step enable; 0 holds PC and state
//   branch    in   branch taken (already flag-qualified by the decoder)
//   br_abs    in   1 = absolute target, 0 = PC-relative offset
//   br_addr   in   absolute target or two's-complement relative offset
//   wait_req  in   current instruction is wait-for-handshake
//   halt_req  in   current instruction is halt
//   hs_in     in   external handshake switch
//   address   out  current PC, straight to program memory
//   waiting   out  1 while waiting for handshake press or release
//   halted    out  1 while halted
//
// State table:
//   state          | meaning
//   ---------------+-------------------------------------------------------
//   S_RUN          | fetching; requests applied by priority each enabled cycle
//   S_WAIT_ASSERT  | on a wait instruction, waiting for the handshake press
//   S_WAIT_RELEASE | press seen, waiting for release; release steps PC past it
//   S_HALT         | stopped; only reset leaves this state

module pc_sequencer #(
    parameter int P_SIZE = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              branch,
    input  logic              br_abs,
    input  logic [P_SIZE-1:0] br_addr,
    input  logic              wait_req,
    input  logic              halt_req,
    input  logic              hs_in,
    output logic [P_SIZE-1:0] address,
    output logic              waiting,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_RUN          = 2'd0,
        S_WAIT_ASSERT  = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_HALT         = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [P_SIZE-1:0] pc;
    logic [P_SIZE-1:0] pc_nxt;
    logic              hs_s;

    //------------------------------------------------------------------
    // Handshake conditioning
    //------------------------------------------------------------------
`ifdef PC_HS_SYNC_EN
    logic hs_meta;
    logic hs_sync;

    // Free-running regardless of en: edges seen while stalled are not
    // latched, the FSM simply looks at the current level once en returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_meta <= 1'b0;
            hs_sync <= 1'b0;
        end else begin
            hs_meta <= hs_in;
            hs_sync <= hs_meta;
        end
    end

    assign hs_s = hs_sync;
`else
    assign hs_s = hs_in;
`endif

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (en) begin
            case (state)
                S_RUN: begin
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else if (wait_req) begin
                        state_nxt = S_WAIT_ASSERT;
                    end else if (branch) begin
                        // Same-width add wraps modulo 2^P_SIZE, which is exactly
                        // a sign-extended offset truncated back to P_SIZE bits.
                        pc_nxt = br_abs ? br_addr : (pc + br_addr);
                    end else begin
                        pc_nxt = pc + P_SIZE'(1);
                    end
                end
                S_WAIT_ASSERT: begin
                    if (hs_s) begin
                        state_nxt = S_WAIT_RELEASE;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (!hs_s) begin
                        state_nxt = S_RUN;
                        pc_nxt    = pc + P_SIZE'(1);
                    end
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Output decode
    //------------------------------------------------------------------
    always_comb begin
        address = pc;
        waiting = (state == S_WAIT_ASSERT) || (state == S_WAIT_RELEASE);
        halted  = (state == S_HALT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int P_SIZE = 5;
    localparam int MODN   = 1 << P_SIZE;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              branch;
    logic              br_abs;
    logic [P_SIZE-1:0] br_addr;
    logic              wait_req;
    logic              halt_req;
    logic              hs_in;
    logic [P_SIZE-1:0] address;
    logic              waiting;
    logic              halted;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.P_SIZE(P_SIZE)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .branch   (branch),
        .br_abs   (br_abs),
        .br_addr  (br_addr),
        .wait_req (wait_req),
        .halt_req (halt_req),
        .hs_in    (hs_in),
        .address  (address),
        .waiting  (waiting),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: program position plus a "phase" describing what the
    // program is blocked on (nothing / press / release / stopped for good).
    // ------------------------------------------------------------------
    int m_pc;
    bit m_stopped;
    bit m_need_press;
    bit m_need_release;
    bit m_h1, m_h2;
    bit model_live = 0;

    function automatic int signed_off(input int v);
        return (v >= MODN / 2) ? v - MODN : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit seen;
        if (reset) begin
            m_pc = 0; m_stopped = 0; m_need_press = 0; m_need_release = 0;
            m_h1 = 0; m_h2 = 0;
        end else begin
`ifdef PC_HS_SYNC_EN
            seen = m_h2;
`else
            seen = hs_in;
`endif
            m_h2 = m_h1;
            m_h1 = hs_in;
            if (en) begin
                if (m_stopped) begin
                    // nothing moves
                end else if (m_need_press) begin
                    if (seen) begin m_need_press = 0; m_need_release = 1; end
                end else if (m_need_release) begin
                    if (!seen) begin m_need_release = 0; m_pc = (m_pc + 1) % MODN; end
                end else if (halt_req) begin
                    m_stopped = 1;
                end else if (wait_req) begin
                    m_need_press = 1;
                end else if (branch && br_abs) begin
                    m_pc = int'(br_addr);
                end else if (branch) begin
                    m_pc = (m_pc + signed_off(int'(br_addr)) + MODN) % MODN;
                end else begin
                    m_pc = (m_pc + 1) % MODN;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live && !reset) begin
            check("model_address", int'(address), m_pc);
            check("model_waiting", int'(waiting), int'(m_need_press || m_need_release));
            check("model_halted",  int'(halted),  int'(m_stopped));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for address to leave its current value; returns cycles used.
    task automatic wait_move(input string name, input int limit, output int used);
        int start;
        start = int'(address);
        used = 0;
        while (int'(address) == start && used < limit) begin
            step(1);
            used++;
        end
        if (int'(address) == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: address stuck at %0d after %0d cycles", name, start, limit);
        end
    endtask

    int used;
`ifdef PC_HS_SYNC_EN
    localparam int REL_LAT = 3;
`else
    localparam int REL_LAT = 1;
`endif

    initial begin
        reset = 1; en = 0; branch = 0; br_abs = 0; br_addr = '0;
        wait_req = 0; halt_req = 0; hs_in = 0;
        #3;
        check("reset_address", int'(address), 0);
        check("reset_waiting", int'(waiting), 0);
        check("reset_halted",  int'(halted),  0);
        #4;
        reset = 0;
        en = 1;
        model_live = 1;

        // Increment and wrap
        step(31);
        check("inc_31", int'(address), 31);
        step(1);
        check("inc_wrap0", int'(address), 0);
        step(1);
        check("inc_wrap1", int'(address), 1);

        // Hold with en low, branch present
        step(6);
        check("pre_hold", int'(address), 7);
        en = 0; branch = 1; br_abs = 1; br_addr = 5'd3;
        step(4);
        check("hold_7", int'(address), 7);
        en = 1; branch = 0;
        step(1);
        check("resume_8", int'(address), 8);

        // Branches
        branch = 1; br_abs = 1; br_addr = 5'd3;
        step(1);
        check("abs_3", int'(address), 3);
        br_abs = 0; br_addr = 5'h1E;
        step(1);
        check("rel_m2_to1", int'(address), 1);
        step(1);
        check("rel_m2_wrap31", int'(address), 31);
        br_addr = 5'd2;
        step(1);
        check("rel_p2_wrap1", int'(address), 1);
        br_abs = 1; br_addr = 5'd20;
        step(1);
        check("abs_20", int'(address), 20);
        br_addr = 5'd10;
        step(1);
        check("abs_10", int'(address), 10);
        branch = 0;

        // Handshake: press then release
        wait_req = 1;
        step(1);
        wait_req = 0;
        check("wait_enter_addr", int'(address), 10);
        check("wait_enter_flag", int'(waiting), 1);
        hs_in = 1;
        step(5);
        check("wait_pressed_addr", int'(address), 10);
        check("wait_pressed_flag", int'(waiting), 1);
        hs_in = 0;
        wait_move("release_advance", 10, used);
        check("release_latency", used, REL_LAT);
        check("release_addr", int'(address), 11);
        check("release_flag", int'(waiting), 0);

        // Enter wait with the switch already pressed: only the release is needed
        hs_in = 1; wait_req = 1;
        step(1);
        wait_req = 0;
        step(3);
        check("prepressed_addr", int'(address), 11);
        check("prepressed_flag", int'(waiting), 1);
        hs_in = 0;
        wait_move("prepressed_release", 10, used);
        check("prepressed_next", int'(address), 12);
        check("prepressed_done", int'(waiting), 0);

        // Priority: halt beats wait and branch; halt is sticky
        halt_req = 1; wait_req = 1; branch = 1; br_abs = 1; br_addr = 5'd5;
        step(1);
        check("halt_flag", int'(halted), 1);
        check("halt_addr", int'(address), 12);
        check("halt_nowait", int'(waiting), 0);
        for (int i = 0; i < 20; i++) begin
            halt_req = 1'($urandom_range(0, 1));
            wait_req = 1'($urandom_range(0, 1));
            branch   = 1'($urandom_range(0, 1));
            br_abs   = 1'($urandom_range(0, 1));
            br_addr  = P_SIZE'($urandom_range(0, MODN - 1));
            hs_in    = 1'($urandom_range(0, 1));
            step(1);
        end
        check("halt_sticky_addr", int'(address), 12);
        check("halt_sticky_flag", int'(halted), 1);
        halt_req = 0; wait_req = 0; branch = 0; hs_in = 0;

        // Reset leaves halt
        #2 reset = 1;
        #1;
        check("halt_reset_addr", int'(address), 0);
        check("halt_reset_flag", int'(halted), 0);
        #2 reset = 0;
        step(1);

        // Reset asynchronously in WAIT_RELEASE at address 9
        branch = 1; br_abs = 1; br_addr = 5'd9;
        step(1);
        branch = 0;
        wait_req = 1;
        step(1);
        wait_req = 0; hs_in = 1;
        step(4);
        check("wr_addr", int'(address), 9);
        check("wr_flag", int'(waiting), 1);
        #2 reset = 1;
        #1;
        check("async_reset_addr", int'(address), 0);
        check("async_reset_wait", int'(waiting), 0);
        hs_in = 0;
        #2 reset = 0;
        step(3);
        check("post_reset_inc", int'(address), 3);
        check("post_reset_wait", int'(waiting), 0);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
